// File: rtl/pipe_exmem_pkg.sv
// Shared constants for the EX/MEM/WB pipeline slice: default widths and the
// hard-wired zero register.
package pipe_exmem_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int R0 = 0;
endpackage

// File: rtl/pipe_exmem_fwd_sel.sv
// Per-operand bypass mux: selects the youngest in-flight producer of register
// address a, falling back to the register file. r0 is never bypassed.
module pipe_fwd_sel #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] rf,
  input  logic [DW-1:0] e_wd,
  input  logic [AW-1:0] e_wa,
  input  logic          e_wreg,
  input  logic          e_m2reg,
  input  logic [DW-1:0] m_wd,
  input  logic [AW-1:0] m_wa,
  input  logic          m_wreg,
  input  logic [DW-1:0] w_wd,
  input  logic [AW-1:0] w_wa,
  input  logic          w_wreg,
  output logic [DW-1:0] op
);
  import pipe_exmem_pkg::*;

  logic nz;
  assign nz = (a != AW'(R0));

  // A load in EXE has no data yet; load_stall covers that case.
  always_comb begin
    op = rf;
    if (nz) begin
      if (e_wreg && !e_m2reg && e_wa == a) op = e_wd;
      else if (m_wreg && m_wa == a)        op = m_wd;
      else if (w_wreg && w_wa == a)        op = w_wd;
    end
  end
endmodule

// File: rtl/pipe_exmem.sv
// EX/MEM and MEM/WB pipeline registers with operand bypass to decode and
// load-use hazard detection.
module pipe_exmem #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] e_wd,
  input  logic [AW-1:0] e_wa,
  input  logic          e_wreg,
  input  logic          e_m2reg,
  input  logic          e_wmem,
  input  logic [DW-1:0] e_st,
  input  logic          hold,
  input  logic          flush,
  input  logic [DW-1:0] m_rdata,
  output logic [DW-1:0] m_alu,
  output logic [DW-1:0] m_st,
  output logic [AW-1:0] m_wa,
  output logic          m_wreg,
  output logic          m_m2reg,
  output logic          m_wmem,
  output logic [DW-1:0] w_wd,
  output logic [AW-1:0] w_wa,
  output logic          w_wreg,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [DW-1:0] d_rf1,
  input  logic [DW-1:0] d_rf2,
  output logic [DW-1:0] d_op1,
  output logic [DW-1:0] d_op2,
  output logic          load_stall
);
  import pipe_exmem_pkg::*;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] st;
    logic [AW-1:0] wa;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
  } exmem_t;

  typedef struct packed {
    logic [DW-1:0] wd;
    logic [AW-1:0] wa;
    logic          wreg;
  } memwb_t;

  exmem_t mq;
  memwb_t wq;
  logic [DW-1:0] m_wd;

  // m_rdata only reaches state through this mux into MEM/WB.
  assign m_wd = mq.m2reg ? m_rdata : mq.alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq <= '0;
      wq <= '0;
    end else if (!hold) begin
      mq.alu   <= e_wd;
      mq.st    <= e_st;
      mq.wa    <= e_wa;
      mq.wreg  <= e_wreg  & ~flush;
      mq.m2reg <= e_m2reg & ~flush;
      mq.wmem  <= e_wmem  & ~flush;
      wq.wd    <= m_wd;
      wq.wa    <= mq.wa;
      wq.wreg  <= mq.wreg;
    end
  end

  assign m_alu   = mq.alu;
  assign m_st    = mq.st;
  assign m_wa    = mq.wa;
  assign m_wreg  = mq.wreg;
  assign m_m2reg = mq.m2reg;
  assign m_wmem  = mq.wmem;
  assign w_wd    = wq.wd;
  assign w_wa    = wq.wa;
  assign w_wreg  = wq.wreg;

  logic [1:0][AW-1:0] src;
  logic [1:0][DW-1:0] rf, op;
  assign src = {d_rt, d_rs};
  assign rf  = {d_rf2, d_rf1};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    pipe_fwd_sel #(.DW(DW), .AW(AW)) u_sel (
      .a(src[i]), .rf(rf[i]),
      .e_wd(e_wd), .e_wa(e_wa), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
      .m_wd(m_wd), .m_wa(mq.wa), .m_wreg(mq.wreg),
      .w_wd(wq.wd), .w_wa(wq.wa), .w_wreg(wq.wreg),
      .op(op[i])
    );
  end

  assign d_op1 = op[0];
  assign d_op2 = op[1];

  assign load_stall = e_wreg && e_m2reg && (e_wa != AW'(R0)) &&
                      ((d_use_rs && e_wa == d_rs) || (d_use_rt && e_wa == d_rt));
endmodule
